// File: rtl/led_pwm_pkg.sv
// Purpose: shared types and constants for the LED palette PWM renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pwm_pkg;

  localparam int c_pwm_steps = 255;
  localparam int c_duty_w    = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Phase offset of LED k in a group of n LEDs; k < n keeps the product below 255.
  function automatic logic [c_duty_w-1:0] stagger_offset(input int k, input int n);
    return c_duty_w'((k * (c_pwm_steps / n)) % c_pwm_steps);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// Purpose: one PWM comparator, drives high while (step + offset) mod 255 < duty.
// Latency: one clock from step/duty inputs to o_pwm.
// Backpressure: none; free-running output with no handshake.
module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_srst,
  input  logic [c_duty_w-1:0] i_step,
  input  logic [c_duty_w-1:0] i_offset,
  input  logic [c_duty_w-1:0] i_duty,
  output logic                o_pwm
);

  logic [c_duty_w:0]   w_sum;
  logic [c_duty_w-1:0] w_eff_step;
  logic                r_pwm;

  // Effective step: offset added modulo the period length; step and offset are both < 255.
  always_comb begin
    w_sum      = {1'b0, i_step} + {1'b0, i_offset};
    w_eff_step = w_sum[c_duty_w-1:0];
    if (w_sum >= (c_duty_w+1)'(c_pwm_steps)) begin
      w_eff_step = c_duty_w'(w_sum - (c_duty_w+1)'(c_pwm_steps));
    end
  end

  // Registered compare; duty 0xFF is high on all 255 steps since step never reaches 255.
  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (w_eff_step < i_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/led_palette_pwm_renderer.sv
// Purpose: 255-step PWM for RGB and single-colour LEDs, duties shadowed once per period.
// Latency: one clock from counters to eo_* outputs; duty changes take effect at the next period.
// Backpressure: none; free-running. Macro LED_PWM_STAGGER_EN staggers LED phases within each group.
module led_palette_pwm_renderer
  import led_pwm_pkg::*;
#(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_prescale_count  = 40
) (
  input  logic                                   i_clk,
  input  logic                                   i_srst,
  input  logic [c_duty_w*parm_color_led_count-1:0] i_color_led_red_value,
  input  logic [c_duty_w*parm_color_led_count-1:0] i_color_led_green_value,
  input  logic [c_duty_w*parm_color_led_count-1:0] i_color_led_blue_value,
  input  logic [c_duty_w*parm_basic_led_count-1:0] i_basic_led_lumin_value,
  output logic [parm_color_led_count-1:0]        eo_color_led_red,
  output logic [parm_color_led_count-1:0]        eo_color_led_green,
  output logic [parm_color_led_count-1:0]        eo_color_led_blue,
  output logic [parm_basic_led_count-1:0]        eo_basic_led,
  output logic                                   o_period_strobe
);

  localparam logic [15:0]         c_presc_last = 16'(parm_prescale_count - 1);
  localparam logic [c_duty_w-1:0] c_step_last  = c_duty_w'(c_pwm_steps - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_step_en;

  logic [15:0]         r_presc;
  logic [c_duty_w-1:0] r_step;
  logic                r_strobe;

  logic [c_duty_w*parm_color_led_count-1:0] r_red_shadow;
  logic [c_duty_w*parm_color_led_count-1:0] r_green_shadow;
  logic [c_duty_w*parm_color_led_count-1:0] r_blue_shadow;
  logic [c_duty_w*parm_basic_led_count-1:0] r_basic_shadow;

  // Step enable fires on the terminal prescale count; only counted while running.
  assign w_step_en = (r_state == ST_RUN) && (r_presc == c_presc_last);

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and shadow-load decision: load once on entry, then at each period wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_load = w_step_en && (r_step == c_step_last);
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Prescale and step counters; held at zero during the init cycle.
  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      r_presc <= '0;
      r_step  <= '0;
    end else if (r_state == ST_INIT) begin
      r_presc <= '0;
      r_step  <= '0;
    end else if (w_step_en) begin
      r_presc <= '0;
      r_step  <= (r_step == c_step_last) ? '0 : r_step + 1'b1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Shadow duties: all groups reload together so no LED sees a half-updated palette.
  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      r_red_shadow   <= '0;
      r_green_shadow <= '0;
      r_blue_shadow  <= '0;
      r_basic_shadow <= '0;
    end else if (w_load) begin
      r_red_shadow   <= i_color_led_red_value;
      r_green_shadow <= i_color_led_green_value;
      r_blue_shadow  <= i_color_led_blue_value;
      r_basic_shadow <= i_basic_led_lumin_value;
    end
  end

  // Period strobe: high in the cycle following each shadow load.
  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_load;
    end
  end

  assign o_period_strobe = r_strobe;

  for (genvar k = 0; k < parm_color_led_count; k++) begin : g_color
`ifdef LED_PWM_STAGGER_EN
    localparam logic [c_duty_w-1:0] c_offset = stagger_offset(k, parm_color_led_count);
`else
    localparam logic [c_duty_w-1:0] c_offset = '0;
`endif
    led_pwm_channel u_red (
      .i_clk    (i_clk),
      .i_srst   (i_srst),
      .i_step   (r_step),
      .i_offset (c_offset),
      .i_duty   (r_red_shadow[c_duty_w*k +: c_duty_w]),
      .o_pwm    (eo_color_led_red[k])
    );
    led_pwm_channel u_green (
      .i_clk    (i_clk),
      .i_srst   (i_srst),
      .i_step   (r_step),
      .i_offset (c_offset),
      .i_duty   (r_green_shadow[c_duty_w*k +: c_duty_w]),
      .o_pwm    (eo_color_led_green[k])
    );
    led_pwm_channel u_blue (
      .i_clk    (i_clk),
      .i_srst   (i_srst),
      .i_step   (r_step),
      .i_offset (c_offset),
      .i_duty   (r_blue_shadow[c_duty_w*k +: c_duty_w]),
      .o_pwm    (eo_color_led_blue[k])
    );
  end

  for (genvar k = 0; k < parm_basic_led_count; k++) begin : g_basic
`ifdef LED_PWM_STAGGER_EN
    localparam logic [c_duty_w-1:0] c_offset = stagger_offset(k, parm_basic_led_count);
`else
    localparam logic [c_duty_w-1:0] c_offset = '0;
`endif
    led_pwm_channel u_basic (
      .i_clk    (i_clk),
      .i_srst   (i_srst),
      .i_step   (r_step),
      .i_offset (c_offset),
      .i_duty   (r_basic_shadow[c_duty_w*k +: c_duty_w]),
      .o_pwm    (eo_basic_led[k])
    );
  end

endmodule

// File: tb/tb_led_palette_pwm_renderer.sv
// Purpose: directed check of the LED PWM renderer at prescale 1 and 2.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_palette_pwm_renderer;

  logic        clk = 1'b0;
  bit          clk_en = 1'b1;
  logic        rst = 1'b1;
  logic [31:0] red_v = '0, grn_v = '0, blu_v = '0, bas_v = '0;

  logic [3:0] a_red, a_grn, a_blu, a_bas;
  logic       a_stb;
  logic [3:0] b_red, b_grn, b_blu, b_bas;
  logic       b_stb;

  int n_vec = 0;
  int n_bad = 0;

  always #5 if (clk_en) clk = ~clk;

  led_palette_pwm_renderer #(
    .parm_color_led_count (4),
    .parm_basic_led_count (4),
    .parm_prescale_count  (1)
  ) dut_a (
    .i_clk                   (clk),
    .i_srst                  (rst),
    .i_color_led_red_value   (red_v),
    .i_color_led_green_value (grn_v),
    .i_color_led_blue_value  (blu_v),
    .i_basic_led_lumin_value (bas_v),
    .eo_color_led_red        (a_red),
    .eo_color_led_green      (a_grn),
    .eo_color_led_blue       (a_blu),
    .eo_basic_led            (a_bas),
    .o_period_strobe         (a_stb)
  );

  led_palette_pwm_renderer #(
    .parm_color_led_count (4),
    .parm_basic_led_count (4),
    .parm_prescale_count  (2)
  ) dut_b (
    .i_clk                   (clk),
    .i_srst                  (rst),
    .i_color_led_red_value   (red_v),
    .i_color_led_green_value (grn_v),
    .i_color_led_blue_value  (blu_v),
    .i_basic_led_lumin_value (bas_v),
    .eo_color_led_red        (b_red),
    .eo_color_led_green      (b_grn),
    .eo_color_led_blue       (b_blu),
    .eo_basic_led            (b_bas),
    .o_period_strobe         (b_stb)
  );

  typedef struct {
    logic [7:0] r, g, b, bs;
    int         step;
    logic [3:0] exp;   // {red0, green0, blue0, basic0}
  } vec_t;

  typedef struct {
    int   step;
    logic exp0;
    logic exp1;
  } svec_t;

  vec_t  vecs  [14];
  svec_t svecs [7];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = a_stb;
    end
    if (!seen) check("strobe_wait", 0, 1);
  endtask

  // Leaves the sample point at the output reflecting step s of the first period.
  task automatic sample_at_step(input int s);
    reset_dut();
    wait_strobe();
    repeat (s + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int strobes, highs, lows, first_low, next_high, pos;

    vecs[0]  = '{8'h00, 8'h01, 8'h80, 8'hFF,   0, 4'b0111};
    vecs[1]  = '{8'h00, 8'h01, 8'h80, 8'hFF,   1, 4'b0011};
    vecs[2]  = '{8'h00, 8'h01, 8'h80, 8'hFF, 127, 4'b0011};
    vecs[3]  = '{8'h00, 8'h01, 8'h80, 8'hFF, 128, 4'b0001};
    vecs[4]  = '{8'h00, 8'h01, 8'h80, 8'hFF, 254, 4'b0001};
    vecs[5]  = '{8'hFF, 8'hFE, 8'h40, 8'h00, 253, 4'b1100};
    vecs[6]  = '{8'hFF, 8'hFE, 8'h40, 8'h00, 254, 4'b1000};
    vecs[7]  = '{8'hFF, 8'hFE, 8'h40, 8'h00,  63, 4'b1110};
    vecs[8]  = '{8'hFF, 8'hFE, 8'h40, 8'h00,  64, 4'b1100};
    vecs[9]  = '{8'h10, 8'h20, 8'h30, 8'h01,   0, 4'b1111};
    vecs[10] = '{8'h10, 8'h20, 8'h30, 8'h01,  15, 4'b1110};
    vecs[11] = '{8'h10, 8'h20, 8'h30, 8'h01,  16, 4'b0110};
    vecs[12] = '{8'h10, 8'h20, 8'h30, 8'h01,  47, 4'b0010};
    vecs[13] = '{8'h10, 8'h20, 8'h30, 8'h01,  48, 4'b0000};

`ifdef LED_PWM_STAGGER_EN
    svecs[0] = '{  0, 1'b1, 1'b1};
    svecs[1] = '{  1, 1'b1, 1'b0};
    svecs[2] = '{ 63, 1'b1, 1'b0};
    svecs[3] = '{ 64, 1'b0, 1'b0};
    svecs[4] = '{191, 1'b0, 1'b0};
    svecs[5] = '{192, 1'b0, 1'b1};
    svecs[6] = '{254, 1'b0, 1'b1};
`else
    svecs[0] = '{  0, 1'b1, 1'b1};
    svecs[1] = '{  1, 1'b1, 1'b1};
    svecs[2] = '{ 63, 1'b1, 1'b1};
    svecs[3] = '{ 64, 1'b0, 1'b0};
    svecs[4] = '{191, 1'b0, 1'b0};
    svecs[5] = '{192, 1'b0, 1'b0};
    svecs[6] = '{254, 1'b0, 1'b0};
`endif

    // Reset state while held in reset, with inputs non-zero.
    red_v = 32'hFFFF_FFFF; bas_v = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", int'({a_red, a_grn, a_blu, a_bas, a_stb}), 0);
    check("reset_outs_b", int'({b_red, b_grn, b_blu, b_bas, b_stb}), 0);

    // All duties zero: outputs stay low, four strobes over 766 edges after release.
    red_v = '0; grn_v = '0; blu_v = '0; bas_v = '0;
    reset_dut();
    strobes = 0; highs = 0;
    for (int i = 0; i < 766; i++) begin
      @(posedge clk);
      #1;
      if (a_stb) strobes++;
      if ({a_red, a_grn, a_blu, a_bas} != '0) highs++;
    end
    check("zero_duty_strobes", strobes, 4);
    check("zero_duty_highs", highs, 0);

    // Table: LED0 of each group at selected steps, prescale 1.
    for (int i = 0; i < 14; i++) begin
      red_v = {24'h0, vecs[i].r};
      grn_v = {24'h0, vecs[i].g};
      blu_v = {24'h0, vecs[i].b};
      bas_v = {24'h0, vecs[i].bs};
      sample_at_step(vecs[i].step);
      check($sformatf("vec%0d_step%0d", i, vecs[i].step),
            int'({a_red[0], a_grn[0], a_blu[0], a_bas[0]}), int'(vecs[i].exp));
    end

    // Basic LED0 at 0xFF stays high from the cycle after the first strobe.
    red_v = '0; grn_v = '0; blu_v = '0; bas_v = 32'h0000_00FF;
    reset_dut();
    wait_strobe();
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (!a_bas[0]) lows++;
    end
    check("full_duty_low_cycles", lows, 0);

    // Prescale 2, red0 0x80: 256 high then 254 low per 510-cycle period.
    red_v = 32'h0000_0080; bas_v = '0;
    reset_dut();
    wait_strobe();
    highs = 0; first_low = 0; next_high = 0; strobes = 0;
    for (int i = 1; i <= 1020; i++) begin
      @(posedge clk);
      #1;
      if (b_red[0]) highs++;
      if (b_stb) strobes++;
      if (!b_red[0] && first_low == 0) first_low = i;
      if (b_red[0] && first_low != 0 && next_high == 0) next_high = i;
    end
    check("p2_high_run", first_low - 1, 256);
    check("p2_low_run", next_high - first_low, 254);
    check("p2_total_high", highs, 512);
    check("p2_strobes", strobes, 2);

    // Duty change mid-period is deferred to the next period.
    red_v = '0; grn_v = 32'h0000_1000;
    reset_dut();
    wait_strobe();
    highs = 0; lows = 0; pos = 0;
    for (int i = 1; i <= 510; i++) begin
      @(posedge clk);
      #1;
      if (a_grn[1]) begin
        if (i <= 255) highs++;
        else lows++;
      end
      if (a_stb && pos == 0) pos = i;
      if (i == 100) grn_v = 32'h0000_F000;
    end
    check("defer_old_width", highs, 16);
    check("defer_new_width", lows, 240);
    check("defer_strobe_pos", pos, 255);

    // Asynchronous reset with the clock stopped, then restart.
    grn_v = '0; red_v = 32'h0000_00FF;
    reset_dut();
    wait_strobe();
    repeat (50) @(posedge clk);
    #1;
    check("pre_reset_red0", int'(a_red[0]), 1);
    clk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_red0", int'(a_red[0]), 0);
    check("async_reset_strobe", int'(a_stb), 0);
    #5;
    rst = 1'b0;
    #1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("restart_strobe", int'(a_stb), 1);
    check("restart_red0_first", int'(a_red[0]), 0);
    @(posedge clk);
    #1;
    check("restart_red0_second", int'(a_red[0]), 1);
    check("restart_strobe_gone", int'(a_stb), 0);

    // Red LED0 and LED1 at 0x40: LED1 phase depends on the stagger build.
    red_v = 32'h0000_4040;
    for (int i = 0; i < 7; i++) begin
      sample_at_step(svecs[i].step);
      check($sformatf("stag_led0_step%0d", svecs[i].step), int'(a_red[0]), int'(svecs[i].exp0));
      check($sformatf("stag_led1_step%0d", svecs[i].step), int'(a_red[1]), int'(svecs[i].exp1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/led_palette_pwm_renderer.md
LED_PALETTE_PWM_RENDERER -- requirements
Module: led_palette_pwm_renderer

Interface
REQ-001 SHALL have parameter parm_color_led_count, default 4, number of RGB LEDs.
REQ-002 SHALL have parameter parm_basic_led_count, default 4, number of single-colour LEDs.
REQ-003 SHALL have parameter parm_prescale_count, default 40, clock cycles per PWM step; legal range 1..65535.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: i_clk and i_srst.
REQ-005 SHALL have port i_clk, input, 1, system clock.
REQ-006 SHALL have port i_srst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports i_color_led_red_value, i_color_led_green_value and i_color_led_blue_value, each input, 8*parm_color_led_count, one 8-bit duty per LED, LED k in bits [8k+7:8k].
REQ-008 SHALL have port i_basic_led_lumin_value, input, 8*parm_basic_led_count, one 8-bit duty per basic LED.
REQ-009 SHALL have ports eo_color_led_red, eo_color_led_green and eo_color_led_blue, each output, parm_color_led_count, registered PWM drive, active-high.
REQ-010 SHALL have port eo_basic_led, output, parm_basic_led_count, registered PWM drive, active-high.
REQ-011 SHALL have port o_period_strobe, output, 1, one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-012 SHALL count prescale cycles 0..parm_prescale_count-1; at the terminal value the count SHALL wrap to 0 and issue a step enable.
REQ-013 SHALL advance the PWM step count 0..254 on each step enable and wrap 254->0, giving 255 steps per period.
REQ-014 SHALL implement FSM states ST_INIT and ST_RUN; reset SHALL enter ST_INIT.
REQ-015 In ST_INIT, on the first clock after reset release, SHALL load all duty inputs into shadow registers, clear both counters and go to ST_RUN.
REQ-016 In ST_RUN, SHALL reload the shadow registers only on the step enable where the step count is 254, i.e. the period wrap.
REQ-017 SHALL ignore input changes between reloads; outputs SHALL never show a partially updated duty.
REQ-018 SHALL drive each output bit, registered, to (effective step count < shadow duty); latency is one clock from the counter.
REQ-019 Duty 0x00 SHALL give a constant low; duty 0xFF SHALL give a constant high (255 of 255 steps).
REQ-020 Duty d SHALL give exactly d*parm_prescale_count high cycles per period.
REQ-021 SHALL assert o_period_strobe for exactly one cycle, in the cycle after each shadow load, including the ST_INIT load.
REQ-022 SHALL treat parm_prescale_count = 1 as a step enable on every clock.

Reset
REQ-023 While i_srst is high, with no clock edge needed, all eo_* outputs, o_period_strobe, both counters and all shadow registers SHALL be 0.
REQ-024 Reset asserted mid-period SHALL abandon the period; after release, operation SHALL restart at ST_INIT.

Configuration
REQ-025 Macro LED_PWM_STAGGER_EN SHALL select per-LED phase staggering.
REQ-026 With LED_PWM_STAGGER_EN defined, the effective step count for LED index k in each group SHALL be (step + k*(255/group_count)) mod 255, using integer division. This staggers LED edges.
REQ-027 Without LED_PWM_STAGGER_EN, the effective step count SHALL equal the step count for every LED. Duty totals (REQ-020) SHALL be identical in both builds.

Structure
REQ-028 The FSM state type (ST_INIT, ST_RUN), the constant c_pwm_steps = 255 and the duty width constant 8 SHALL reside in a shared package led_pwm_pkg.
REQ-029 The comparator SHALL be one sub-module, led_pwm_channel: it takes the step count, a static offset and the shadow duty, and produces a registered output. It SHALL be instantiated per LED and per colour with generate loops.

Verification
REQ-030 prescale=1, all duties 0x00, run 3 periods (765 clk) -> every eo_* stays 0; o_period_strobe pulses 4 times (init plus 3 wraps).
REQ-031 prescale=1, basic LED0 duty 0xFF -> eo_basic_led[0] is constantly 1 from the cycle after the first strobe.
REQ-032 prescale=2, red LED0 duty 0x80 -> 256 high cycles followed by 254 low cycles per 510-cycle period, measured over 2 periods.
REQ-033 prescale=1, green LED1 duty changed 0x10->0xF0 at step 100 -> output keeps the 16-step high width until the next strobe, then shows a 240-step width.
REQ-034 Assert i_srst at step 50 with no clock running -> outputs go to 0 immediately; after release -> strobe on the 2nd clock, then normal PWM.
REQ-035 LED_PWM_STAGGER_EN defined, prescale=1, color count 4, red LED1 duty 0x40 -> high only at steps 192..254 and step 0 (64 steps); red LED0 duty 0x40 -> high at steps 0..63.
